cache_trace_ctrl: RTL and testbench
===================================

Name: cache_trace_ctrl

Overview:
- Sequencer between the trace ROM (`trace_file`) and a single `cache_set`.
- Steps through trace references and splits each 32-bit address into tag, index and offset.
- Drives the cache search/update state, resolves hit or miss, and holds the cache in update for a miss-fill penalty.
- Accumulates hit, miss and reference statistics for the bench.
- Replaces the ad-hoc two-state toggle in the top-level bench.

Parameters:
- ADDR_W, 32: width of a trace reference.
- OFFSET_W, 4: block offset bits (ref[OFFSET_W-1:0]).
- INDEX_W, 1: set index bits (ref[OFFSET_W+INDEX_W-1:OFFSET_W]).
- TAG_W, ADDR_W-OFFSET_W-INDEX_W: tag bits (upper bits of ref).
- TRACE_LEN, 16'd1024: maximum references per run.
- MISS_PENALTY, 4: cycles held in FILL per miss (must be >=1).
- END_MARK, 32'hFFFF_FFFF: trace sentinel that terminates a run.

Ports:
- clk, in, 1: system clock; all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a run; sampled only in IDLE or DONE.
- trace_addr, out, 16: address to `trace_file`.
- trace_ref, in, ADDR_W: reference from `trace_file`; combinational from trace_addr.
- cache_tag, out, TAG_W: tag to `cache_set`.
- cache_index, out, INDEX_W: set index.
- cache_offset, out, OFFSET_W: block offset.
- cache_state, out, 1: 0 = search, 1 = update/fill.
- cache_fill, out, 1: high during FILL; allocate strobe.
- cache_hit, in, 1: hit result; valid in RESOLVE.
- busy, out, 1: run in progress.
- done, out, 1: run complete; held.
- ref_count, out, 16: references processed.
- hit_count, out, 32: hits.
- miss_count, out, 32: misses.

Behaviour:
Reset (sync, rst=1 at posedge, overrides everything including mid-run):
- state=IDLE.
- trace_addr=0, ref_q=0; cache_tag/index/offset=0.
- cache_state=0, cache_fill=0, busy=0, done=0.
- All counters=0; fill counter=0.

States, with one transition per posedge:
- IDLE: start=1 -> FETCH; counters and trace_addr cleared that edge.
- FETCH:
  - Latch trace_ref into ref_q.
  - If trace_ref==END_MARK or ref_count==TRACE_LEN -> DONE (the reference is not counted).
  - Else -> SEARCH.
- SEARCH: cache_state=0; cache_tag/index/offset driven from ref_q slices (registered, stable through RESOLVE) -> RESOLVE.
- RESOLVE:
  - Sample cache_hit.
  - Hit: hit_count+1 -> NEXT.
  - Miss: miss_count+1, load fill counter with MISS_PENALTY-1 -> FILL.
- FILL:
  - cache_state=1, cache_fill=1; tag/index/offset held.
  - Counter decrements; at 0 -> NEXT.
  - Exactly MISS_PENALTY cycles in FILL.
- NEXT:
  - ref_count+1.
  - If trace_addr==16'hFFFF -> DONE (no wrap to 0).
  - Else trace_addr+1 -> FETCH.
- DONE:
  - done=1, busy=0; counters frozen.
  - start=1 -> FETCH with counters cleared, done=0 next cycle.

Outputs and latency:
- busy=1 in FETCH/SEARCH/RESOLVE/FILL/NEXT.
- cache_state=0 everywhere except FILL; cache_fill matches FILL.
- Latency per reference: hit = 4 cycles (FETCH..NEXT); miss = 4+MISS_PENALTY.

Boundary conditions:
- start while busy: ignored.
- Counters saturate at all-ones and never wrap.
- ref_count increments alongside hit or miss, so invariant ref_count == hit_count+miss_count holds at every NEXT exit.
- Simultaneous rst and start: rst wins.
- cache_hit outside RESOLVE: ignored.
- END_MARK at trace_addr 0: DONE with all counts 0 after 2 cycles (IDLE->FETCH->DONE).

Test Plan:
- Reset mid-FILL (rst at cycle 7 of a miss) -> next cycle IDLE, cache_fill=0, busy=0, all counts 0.
- Trace {0x0000_0010, 0x0000_0010, END_MARK}, cache model misses on first lookup then hits, MISS_PENALTY=4 -> miss_count=1, hit_count=1, ref_count=2, done at cycle 1+8+4+1=14 after start.
- Reference 0xABCD_1237 with OFFSET_W=4, INDEX_W=1 -> during SEARCH: cache_offset=4'h7, cache_index=1'b1, cache_tag=27'h55E_6891 (ref[31:5]), cache_state=0.
- TRACE_LEN=3, no END_MARK, all misses -> ref_count=3, miss_count=3, trace_addr=3 at DONE; cache_fill high for exactly 12 cycles total.
- start pulsed while busy, then again in DONE -> first pulse ignored (counts continue); second restarts with counters=0, done deasserted next cycle.
- trace_addr preset path to 16'hFFFF (TRACE_LEN=16'hFFFF, no END_MARK) -> after NEXT at 0xFFFF enters DONE; trace_addr stays 0xFFFF, no wrap.

Source files
------------

// File: rtl/cache_trace_ctrl.sv
// Trace-driven cache sequencer: walks trace references, drives a single cache set through
// search/resolve/fill and keeps saturating hit, miss and reference statistics.
module cache_trace_ctrl #(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        OFFSET_W     = 4,
    parameter int unsigned        INDEX_W      = 1,
    parameter int unsigned        TAG_W        = ADDR_W - OFFSET_W - INDEX_W,
    parameter logic [15:0]        TRACE_LEN    = 16'd1024,
    parameter int unsigned        MISS_PENALTY = 4,
    parameter logic [ADDR_W-1:0]  END_MARK     = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [15:0]         trace_addr,
    input  logic [ADDR_W-1:0]   trace_ref,
    output logic [TAG_W-1:0]    cache_tag,
    output logic [INDEX_W-1:0]  cache_index,
    output logic [OFFSET_W-1:0] cache_offset,
    output logic                cache_state,
    output logic                cache_fill,
    input  logic                cache_hit,
    output logic                busy,
    output logic                done,
    output logic [15:0]         ref_count,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int unsigned FILL_W = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StSearch, StResolve, StFill, StNext, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ref_q;
    logic [FILL_W-1:0]  fill_cnt_q;

    // Address fields come straight from the latched reference, so they stay put until next FETCH.
    assign cache_tag    = ref_q[ADDR_W-1:OFFSET_W+INDEX_W];
    assign cache_index  = ref_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign cache_offset = ref_q[OFFSET_W-1:0];
    assign cache_state  = (state_q == StFill);
    assign cache_fill   = (state_q == StFill);
    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign done         = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StFetch;
            StFetch: begin
                if (trace_ref == END_MARK || ref_count == TRACE_LEN) state_d = StDone;
                else                                                 state_d = StSearch;
            end
            StSearch:  state_d = StResolve;
            StResolve: state_d = cache_hit ? StNext : StFill;
            StFill:    if (fill_cnt_q == '0) state_d = StNext;
            StNext:    state_d = (trace_addr == 16'hFFFF) ? StDone : StFetch;
            StDone:    if (start) state_d = StFetch;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_addr <= '0;
            ref_q      <= '0;
            fill_cnt_q <= '0;
            ref_count  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        trace_addr <= '0;
                        ref_count  <= '0;
                        hit_count  <= '0;
                        miss_count <= '0;
                    end
                end
                StFetch: ref_q <= trace_ref;
                StResolve: begin
                    if (cache_hit) begin
                        if (hit_count != '1) hit_count <= hit_count + 32'd1;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        fill_cnt_q <= FILL_W'(MISS_PENALTY - 1);
                    end
                end
                StFill: if (fill_cnt_q != '0) fill_cnt_q <= fill_cnt_q - 1'b1;
                StNext: begin
                    if (ref_count != '1) ref_count <= ref_count + 16'd1;
                    // Last ROM address ends the run rather than wrapping back to 0.
                    if (trace_addr != 16'hFFFF) trace_addr <= trace_addr + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_trace_ctrl.sv
// Directed bench for cache_trace_ctrl: small trace ROM, optional one-set-per-index cache model.
module tb_cache_trace_ctrl;

    localparam logic [31:0] END = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, start, cache_hit;
    logic [15:0] trace_addr, ref_count;
    logic [31:0] trace_ref, hit_count, miss_count;
    logic [26:0] cache_tag;
    logic [0:0]  cache_index;
    logic [3:0]  cache_offset;
    logic        cache_state, cache_fill, busy, done;

    logic [31:0] rom [8];
    logic [26:0] m_tag [2];
    logic        m_valid [2];
    logic        hit_mode, model_clr, fill_clr;
    int          fill_cycles;
    int          checks = 0;
    int          failures = 0;
    int          n;

    always #5 clk = ~clk;

    cache_trace_ctrl #(.TRACE_LEN(16'd3), .MISS_PENALTY(4)) dut (
        .clk(clk), .rst(rst), .start(start), .trace_addr(trace_addr), .trace_ref(trace_ref),
        .cache_tag(cache_tag), .cache_index(cache_index), .cache_offset(cache_offset),
        .cache_state(cache_state), .cache_fill(cache_fill), .cache_hit(cache_hit),
        .busy(busy), .done(done), .ref_count(ref_count), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    assign trace_ref = rom[trace_addr[2:0]];
    assign cache_hit = hit_mode && m_valid[cache_index] && (m_tag[cache_index] == cache_tag);

    always @(posedge clk) begin
        if (model_clr) begin
            m_valid[0] <= 1'b0;
            m_valid[1] <= 1'b0;
        end else if (cache_fill) begin
            m_valid[cache_index] <= 1'b1;
            m_tag[cache_index]   <= cache_tag;
        end
        if (fill_clr) fill_cycles <= 0;
        else if (cache_fill) fill_cycles <= fill_cycles + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [26:0] tag;
        logic        idx;
        logic [3:0]  off;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges until done, bounded; an expired bound shows up as a failed check.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
        end
        check("done_reached", {31'b0, done}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'hABCD_1237, 27'h55E_6891, 1'b1, 4'h7};
        vecs[1] = '{32'h0000_0010, 27'h000_0000, 1'b1, 4'h0};
        vecs[2] = '{32'h8000_000F, 27'h400_0000, 1'b0, 4'hF};
        vecs[3] = '{32'h1234_5678, 27'h091_A2B3, 1'b1, 4'h8};
        vecs[4] = '{32'hFFFF_FFEF, 27'h7FF_FFFF, 1'b0, 4'hF};
        for (int i = 0; i < 8; i++) rom[i] = END;

        rst = 1'b1; start = 1'b1; hit_mode = 1'b0; model_clr = 1'b1; fill_clr = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_fill", {31'b0, cache_fill}, 0);
        check("rst_cstate", {31'b0, cache_state}, 0);
        check("rst_taddr", {16'b0, trace_addr}, 0);
        check("rst_tag", {5'b0, cache_tag}, 0);
        check("rst_counts", {16'b0, ref_count} | hit_count | miss_count, 0);
        rst = 1'b0; start = 1'b0; model_clr = 1'b0; fill_clr = 1'b0;
        tick();
        check("idle_busy", {31'b0, busy}, 0);

        // END_MARK at address 0: IDLE -> FETCH -> DONE.
        pulse_start();
        check("end0_busy", {31'b0, busy}, 1);
        wait_done(n);
        check("end0_cycles", n, 1);
        check("end0_counts", {16'b0, ref_count} | hit_count | miss_count, 0);
        check("end0_busy_off", {31'b0, busy}, 0);

        // Address split table, all lookups miss.
        for (int i = 0; i < 5; i++) begin
            rom[0] = vecs[i].addr;
            rom[1] = END;
            pulse_start();
            tick();
            check($sformatf("v%0d_tag", i), {5'b0, cache_tag}, {5'b0, vecs[i].tag});
            check($sformatf("v%0d_idx", i), {31'b0, cache_index}, {31'b0, vecs[i].idx});
            check($sformatf("v%0d_off", i), {28'b0, cache_offset}, {28'b0, vecs[i].off});
            check($sformatf("v%0d_cstate", i), {31'b0, cache_state}, 0);
            wait_done(n);
            check($sformatf("v%0d_miss", i), miss_count, 1);
            check($sformatf("v%0d_hit", i), hit_count, 0);
            check($sformatf("v%0d_ref", i), {16'b0, ref_count}, 1);
        end

        // Miss then hit on the same line: done 13 edges after the start edge.
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
        hit_mode = 1'b1;
        rom[0] = 32'h10; rom[1] = 32'h10; rom[2] = END;
        pulse_start();
        wait_done(n);
        check("mh_cycles", n, 13);
        check("mh_miss", miss_count, 1);
        check("mh_hit", hit_count, 1);
        check("mh_ref", {16'b0, ref_count}, 2);
        hit_mode = 1'b0;

        // TRACE_LEN=3 limit with no END_MARK, all misses.
        for (int i = 0; i < 8; i++) rom[i] = 32'h1000 + 32'(i) * 32'h20;
        fill_clr = 1'b1;
        tick();
        fill_clr = 1'b0;
        pulse_start();
        wait_done(n);
        check("tl_ref", {16'b0, ref_count}, 3);
        check("tl_miss", miss_count, 3);
        check("tl_taddr", {16'b0, trace_addr}, 3);
        check("tl_fill_cycles", fill_cycles, 12);

        // start while busy is ignored; start in DONE restarts with cleared counters.
        rom[0] = 32'h100; rom[1] = 32'h200; rom[2] = END;
        pulse_start();
        tick(); tick(); tick();
        check("sb_in_fill", {31'b0, cache_fill}, 1);
        check("sb_cstate_fill", {31'b0, cache_state}, 1);
        pulse_start();
        check("sb_busy", {31'b0, busy}, 1);
        check("sb_miss_kept", miss_count, 1);
        wait_done(n);
        check("sb_ref", {16'b0, ref_count}, 2);
        check("sb_miss", miss_count, 2);
        pulse_start();
        check("rs_done_low", {31'b0, done}, 0);
        check("rs_cleared", {16'b0, ref_count} | miss_count, 0);
        wait_done(n);
        check("rs_miss", miss_count, 2);

        // Reset mid-FILL, with start asserted alongside: reset wins.
        rom[0] = 32'h40; rom[1] = END;
        pulse_start();
        tick(); tick(); tick(); tick();
        check("rf_in_fill", {31'b0, cache_fill}, 1);
        rst = 1'b1; start = 1'b1;
        tick();
        check("rf_fill", {31'b0, cache_fill}, 0);
        check("rf_busy", {31'b0, busy}, 0);
        check("rf_counts", {16'b0, ref_count} | hit_count | miss_count, 0);
        check("rf_taddr", {16'b0, trace_addr}, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("rf_idle", {30'b0, busy, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
